// File: rtl/if_fetch_pkg.sv
// Shared CPU fetch-stage types and constants: fetch FSM state, bubble word and PC step.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StValid = 2'd1,
    StKill  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
interface if_fetch_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_data_i
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: REQ/VALID/KILL FSM with redirect handling.
// Optional performance counters are enabled with macro IF_PERF_CNT_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall,
  input  logic        cpu_stall_o,
  input  logic        Flush,
  input  logic [31:0] branch_target_i,
  if_fetch_if.master  imem,
  output logic [31:0] instr,
  output logic [31:0] pc_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] wait_cnt_o
`endif
);

  fetch_state_e r_state_q, w_state_d;
  logic [31:0]  r_pc_q, w_pc_d;
  logic [31:0]  r_tgt_q, w_tgt_d;
  logic [31:0]  r_instr_q, w_instr_d;

  logic        w_advance;
  logic        w_redirect;
  logic        w_req;
  logic [31:0] w_tgt_aligned;

  assign w_advance     = !Stall && !cpu_stall_o;
  assign w_redirect    = Flush && w_advance;
  assign w_tgt_aligned = word_align(branch_target_i);
  assign w_req         = (r_state_q != StValid);

  always_comb begin
    w_state_d = r_state_q;
    w_pc_d    = r_pc_q;
    w_tgt_d   = r_tgt_q;
    w_instr_d = r_instr_q;
    unique case (r_state_q)
      StReq: begin
        if (imem.imem_ready_i) begin
          if (w_redirect) begin
            w_pc_d = w_tgt_aligned;
          end else begin
            w_instr_d = imem.imem_data_i;
            w_state_d = StValid;
          end
        end else if (w_redirect) begin
          // Request already on the bus: keep address stable, remember where to go.
          w_tgt_d   = w_tgt_aligned;
          w_state_d = StKill;
        end
      end
      StKill: begin
        if (imem.imem_ready_i) begin
          w_pc_d    = r_tgt_q;
          w_state_d = StReq;
        end else if (w_redirect) begin
          w_tgt_d = w_tgt_aligned;
        end
      end
      StValid: begin
        if (w_redirect) begin
          w_pc_d    = w_tgt_aligned;
          w_state_d = StReq;
        end else if (w_advance) begin
          w_pc_d    = r_pc_q + PC_STEP;
          w_state_d = StReq;
        end
      end
      default: w_state_d = StReq;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= StReq;
      r_pc_q    <= word_align(RESET_PC);
      r_tgt_q   <= 32'h0;
      r_instr_q <= NOP_BUBBLE;
    end else begin
      r_state_q <= w_state_d;
      r_pc_q    <= w_pc_d;
      r_tgt_q   <= w_tgt_d;
      r_instr_q <= w_instr_d;
    end
  end

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = r_pc_q;
  assign instr            = (r_state_q == StValid) ? r_instr_q : NOP_BUBBLE;
  assign pc_o             = r_pc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt_q;
  logic [31:0] r_wait_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_cnt_q <= 32'h0;
      r_wait_cnt_q  <= 32'h0;
    end else begin
      if (r_state_q == StReq && w_state_d == StValid) begin
        r_fetch_cnt_q <= r_fetch_cnt_q + 32'd1;
      end
      if (w_req && !imem.imem_ready_i) begin
        r_wait_cnt_q <= r_wait_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = r_fetch_cnt_q;
  assign wait_cnt_o  = r_wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios then random stimulus vs a transaction model.
module tb_if_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        cstall;
  logic        flush;
  logic [31:0] target;
  logic [31:0] instr;
  logic [31:0] pc_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] wait_cnt;
`endif

  if_fetch_if imem_bus ();

  if_fetch #(
    .RESET_PC(ResetPc)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .Stall          (stall),
    .cpu_stall_o    (cstall),
    .Flush          (flush),
    .branch_target_i(target),
    .imem           (imem_bus.master),
    .instr          (instr),
    .pc_o           (pc_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fetch_cnt),
    .wait_cnt_o     (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Transaction-level model: either a fetch is outstanding or an instruction is held.
  bit          m_holding;
  bit          m_discard;
  logic [31:0] m_next_tgt;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_fetch;
  logic [31:0] m_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit cs, input bit f,
                              input logic [31:0] t, input bit rdy, input logic [31:0] d);
    bit go;
    bit redir;
    go    = !s && !cs;
    redir = f && go;
    if (r) begin
      m_pc       = ResetPc & 32'hFFFF_FFFC;
      m_next_tgt = 32'h0;
      m_instr    = 32'h0;
      m_holding  = 1'b0;
      m_discard  = 1'b0;
      m_fetch    = 32'h0;
      m_wait     = 32'h0;
    end else if (!m_holding) begin
      if (!rdy) m_wait = m_wait + 1;
      if (rdy) begin
        if (m_discard) begin
          m_pc      = m_next_tgt;
          m_discard = 1'b0;
        end else if (redir) begin
          m_pc = t & 32'hFFFF_FFFC;
        end else begin
          m_instr   = d;
          m_holding = 1'b1;
          m_fetch   = m_fetch + 1;
        end
      end else if (redir) begin
        m_discard  = 1'b1;
        m_next_tgt = t & 32'hFFFF_FFFC;
      end
    end else begin
      if (redir) begin
        m_pc      = t & 32'hFFFF_FFFC;
        m_holding = 1'b0;
      end else if (go) begin
        m_pc      = m_pc + 32'd4;
        m_holding = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit cs, input bit f,
                      input logic [31:0] t, input bit rdy, input logic [31:0] d);
    rst    = r;
    stall  = s;
    cstall = cs;
    flush  = f;
    target = t;
    imem_bus.imem_ready_i = rdy;
    imem_bus.imem_data_i  = d;
    @(posedge clk);
    model_update(r, s, cs, f, t, rdy, d);
    @(negedge clk);
    check("imem_req", {31'b0, imem_bus.imem_req_o}, {31'b0, !m_holding});
    check("imem_addr", imem_bus.imem_addr_o, m_pc);
    check("instr", instr, m_holding ? m_instr : 32'h0);
    check("pc_o", pc_o, m_pc);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("wait_cnt", wait_cnt, m_wait);
`endif
  endtask

  task automatic idle(input bit rdy, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, rdy, d);
  endtask

  initial begin
    logic [31:0] w0;
    n_vec = 0;
    n_err = 0;
    m_holding = 1'b0;
    m_discard = 1'b0;
    m_pc = 32'h0;
    m_instr = 32'h0;
    m_next_tgt = 32'h0;
    m_fetch = 32'h0;
    m_wait = 32'h0;

    // Reset, with a stray ready pulse that must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_addr", imem_bus.imem_addr_o, 32'h0000_0100);
    check("rst_instr", instr, 32'h0);

    // Zero-wait fetch, then sequential advance.
    idle(1'b1, 32'h00A0_0093);
    check("first_instr", instr, 32'h00A0_0093);
    check("first_pc", pc_o, 32'h0000_0100);
    idle(1'b0, 32'h0);
    check("next_addr", imem_bus.imem_addr_o, 32'h0000_0104);

    // Three wait cycles then completion.
    w0 = m_wait;
    for (int i = 0; i < 3; i++) idle(1'b0, 32'h0);
    check("wait_delta", m_wait - w0, 32'd3);
    idle(1'b1, 32'h1111_0104);

    // Hazard stall in VALID for 4 cycles, then release.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    check("stall_hold_pc", pc_o, 32'h0000_0104);
    idle(1'b0, 32'h0);
    check("stall_release", imem_bus.imem_addr_o, 32'h0000_0108);

    // Redirect during an outstanding request at 0x108: ready arrives two cycles later.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2002, 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    check("kill_addr_stable", imem_bus.imem_addr_o, 32'h0000_0108);
    idle(1'b1, 32'hBAD0_0108);
    check("kill_target", imem_bus.imem_addr_o, 32'h0000_2000);
    check("kill_no_instr", instr, 32'h0);
    idle(1'b1, 32'h2222_2000);

    // Flush blocked by Stall in VALID, then accepted.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0);
    check("flush_stalled", pc_o, 32'h0000_2000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0);
    check("flush_taken", imem_bus.imem_addr_o, 32'h0000_3000);

    // Wrap from 0xFFFFFFFC.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    idle(1'b1, 32'h3333_3333);
    idle(1'b0, 32'h0);
    check("wrap_addr", imem_bus.imem_addr_o, 32'h0000_0000);

    // Reset while killing.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("rst_in_kill", imem_bus.imem_addr_o, 32'h0000_0100);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
           ($urandom_range(0, 2) != 0),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
